ballot_arbiter: RTL and testbench

//  Shares one vote-tally counter bank between N_BOOTHS voting booths. Runs a session FSM and

---
 rtl/ballot_arbiter_pkg.sv | 10 +
 rtl/ballot_arbiter_if.sv | 14 +
 rtl/ballot_arbiter_rr.sv | 34 +++
 rtl/ballot_arbiter.sv | 107 ++++++++++
 tb/tb_ballot_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ballot_arbiter_pkg.sv
// ballot_arbiter_pkg: session state encoding, default sizes and reset constants for ballot_arbiter
package ballot_arbiter_pkg;
  typedef enum logic [1:0] {CLOSED = 2'd0, OPEN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam int N_BOOTHS_DEF = 4;
  localparam int N_CAND_DEF = 3;
  localparam int CAND_W_DEF = 2;
  localparam int LOCKOUT_DEF = 15;
  localparam logic [31:0] TOTAL_RST = 32'd0;
  localparam logic [7:0] LOCK_RST = 8'd0;
endpackage

// File: rtl/ballot_arbiter_if.sv
// ballot_arbiter_if: vote handshake between ballot_arbiter (master) and the tally counter bank (slave)
//   o_tally_valid  vote pending          o_tally_cand  candidate of the pending vote
//   o_tally_booth  booth of the vote     i_tally_ready counter bank accepts the vote
interface ballot_arbiter_if import ballot_arbiter_pkg::*; #(
  parameter int CAND_W = CAND_W_DEF,
  parameter int BOOTH_W = 2
) ();
  logic o_tally_valid;
  logic [CAND_W-1:0] o_tally_cand;
  logic [BOOTH_W-1:0] o_tally_booth;
  logic i_tally_ready;
  modport master (output o_tally_valid, o_tally_cand, o_tally_booth, input i_tally_ready);
  modport slave (input o_tally_valid, o_tally_cand, o_tally_booth, output i_tally_ready);
endinterface

// File: rtl/ballot_arbiter_rr.sv
// ballot_arbiter_rr: N-way round-robin arbiter; search starts at the pointer, pointer moves to winner+1 on adv_i
//   clk, rst (async, active-low)   req_i eligible requests   adv_i grant taken
//   gnt_o one-hot winner           idx_o winner index        vld_o any request
module ballot_arbiter_rr #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);
  logic [W-1:0] ptr_q, k;
  // Scan from the farthest offset down so the nearest requester after the pointer is assigned last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(ptr_q) + i) % N);
      if (req_i[k]) begin
        vld_o = 1'b1;
        idx_o = k;
      end
    end
    gnt_o = vld_o ? N'(1) << idx_o : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else if (adv_i) ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
endmodule

// File: rtl/ballot_arbiter.sv
// ballot_arbiter: session FSM sharing one tally bank between booths, round-robin grants, per-booth lockout
//   clk, rst (async, active-low)   i_open/i_close session pulses
//   i_booth_req/i_booth_cand       per-booth request and candidate slice
//   o_booth_ack/rej/busy           per-booth accept pulse, reject pulse, lockout
//   tally                          vote handshake to the counter bank (master)
//   o_state, o_votes_total         session state and votes accepted this session
//   BALLOT_TIMEOUT_EN              drops a vote stalled TIMEOUT_CYC cycles with a reject
module ballot_arbiter import ballot_arbiter_pkg::*; #(
  parameter int N_BOOTHS = N_BOOTHS_DEF,
  parameter int N_CAND = N_CAND_DEF,
  parameter int CAND_W = CAND_W_DEF,
  parameter int BOOTH_W = $clog2(N_BOOTHS),
  parameter int LOCKOUT_CYC = LOCKOUT_DEF
`ifdef BALLOT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_open,
  input  logic                       i_close,
  input  logic [N_BOOTHS-1:0]        i_booth_req,
  input  logic [N_BOOTHS*CAND_W-1:0] i_booth_cand,
  output logic [N_BOOTHS-1:0]        o_booth_ack,
  output logic [N_BOOTHS-1:0]        o_booth_rej,
  output logic [N_BOOTHS-1:0]        o_booth_busy,
  ballot_arbiter_if.master           tally,
  output logic [1:0]                 o_state,
  output logic [31:0]                o_votes_total
);
  state_t state_q;
  logic tvalid_q, vld, adv, xfer, ok;
  logic [CAND_W-1:0] tcand_q, cand_sel;
  logic [BOOTH_W-1:0] tbooth_q, idx;
  logic [N_BOOTHS-1:0] rej_q, gnt, elig;
  logic [7:0] lock_q [N_BOOTHS];
  logic [31:0] total_q;
`ifdef BALLOT_TIMEOUT_EN
  logic [31:0] wait_q;
`endif
  always_comb begin
    o_booth_busy = '0;
    for (int b = 0; b < N_BOOTHS; b++) o_booth_busy[b] = lock_q[b] != LOCK_RST;
  end
  assign elig = i_booth_req & ~o_booth_busy;
  ballot_arbiter_rr #(.N(N_BOOTHS), .W(BOOTH_W)) u_rr (
    .clk(clk), .rst(rst), .req_i(elig), .adv_i(adv), .gnt_o(gnt), .idx_o(idx), .vld_o(vld)
  );
  // A close pulse blocks the grant in its own cycle so nothing new starts once closing is requested.
  assign adv = vld && state_q == OPEN && !tvalid_q && !i_close;
  assign cand_sel = i_booth_cand[int'(idx)*CAND_W +: CAND_W];
  assign ok = int'(cand_sel) < N_CAND;
  assign xfer = tvalid_q && tally.i_tally_ready;
  assign o_booth_ack = xfer ? N_BOOTHS'(1) << tbooth_q : '0;
  assign o_booth_rej = rej_q;
  assign tally.o_tally_valid = tvalid_q;
  assign tally.o_tally_cand = tcand_q;
  assign tally.o_tally_booth = tbooth_q;
  assign o_state = state_q;
  assign o_votes_total = total_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= CLOSED;
      tvalid_q <= 1'b0;
      tcand_q <= '0;
      tbooth_q <= '0;
      rej_q <= '0;
      total_q <= TOTAL_RST;
      for (int b = 0; b < N_BOOTHS; b++) lock_q[b] <= LOCK_RST;
`ifdef BALLOT_TIMEOUT_EN
      wait_q <= '0;
`endif
    end else begin
      rej_q <= '0;
      for (int b = 0; b < N_BOOTHS; b++) lock_q[b] <= (lock_q[b] != LOCK_RST) ? lock_q[b] - 8'd1 : LOCK_RST;
      if (xfer) begin
        tvalid_q <= 1'b0;
        lock_q[tbooth_q] <= 8'(LOCKOUT_CYC);
        total_q <= total_q + 32'(total_q != '1);
      end
`ifdef BALLOT_TIMEOUT_EN
      wait_q <= (tvalid_q && !tally.i_tally_ready) ? wait_q + 32'd1 : '0;
      if (tvalid_q && !tally.i_tally_ready && wait_q == 32'(TIMEOUT_CYC - 1)) begin
        tvalid_q <= 1'b0;
        rej_q <= N_BOOTHS'(1) << tbooth_q;
        wait_q <= '0;
      end
`endif
      // An out-of-range candidate is answered with a reject instead of a tally transfer.
      if (adv) begin
        tcand_q <= cand_sel;
        tbooth_q <= idx;
        tvalid_q <= ok;
        rej_q <= ok ? '0 : gnt;
      end
      case (state_q)
        CLOSED, DONE: if (i_open) begin
          state_q <= OPEN;
          total_q <= TOTAL_RST;
          for (int b = 0; b < N_BOOTHS; b++) lock_q[b] <= LOCK_RST;
        end
        OPEN: if (i_close) state_q <= DRAIN;
        DRAIN: if (!tvalid_q) state_q <= DONE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ballot_arbiter.sv
// tb_ballot_arbiter: randomized and directed stimulus for ballot_arbiter against a cycle-level reference model
module tb_ballot_arbiter;
  localparam int NB = 4, NC = 3, CW = 2, BW = 2, LOCK = 15, TMO = 64;
  logic clk = 1'b0, rst = 1'b0, i_open = 1'b0, i_close = 1'b0;
  logic [NB-1:0] req = '0;
  logic [NB*CW-1:0] cand = '0;
  logic [NB-1:0] ack, rej, busy;
  logic [1:0] state;
  logic [31:0] total;
  ballot_arbiter_if #(.CAND_W(CW), .BOOTH_W(BW)) tif ();
  ballot_arbiter dut (
    .clk(clk), .rst(rst), .i_open(i_open), .i_close(i_close),
    .i_booth_req(req), .i_booth_cand(cand),
    .o_booth_ack(ack), .o_booth_rej(rej), .o_booth_busy(busy),
    .tally(tif), .o_state(state), .o_votes_total(total)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference model: session state, pending vote, and each booth's last acceptance cycle.
  int m_state, m_ptr, m_pbooth, m_pcand, m_cyc, m_stall;
  bit m_pend;
  logic [31:0] m_total;
  bit [NB-1:0] m_rej, m_gnt;
  int m_ackc [NB];
  bit auto_en, hold, force_open, force_close, q_clear;
  int rdy_pct, req_pct;
  bit [NB-1:0] q_req;
  int q_cand [NB];
  task automatic m_clear();
    m_total = 0;
    for (int b = 0; b < NB; b++) m_ackc[b] = -1000;
  endtask
  task automatic m_reset();
    m_state = 0; m_ptr = 0; m_pend = 0; m_rej = '0; m_gnt = '0; m_stall = 0;
    m_pbooth = 0; m_pcand = 0;
    m_clear();
  endtask
  task automatic raise(input int b, input int c);
    q_req[b] = 1'b1;
    q_cand[b] = c;
  endtask
  task automatic tick();
    bit [NB-1:0] bv, nrej;
    bit xfer, np, rdy;
    int win, d;
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      if (q_clear) req[b] = 1'b0;
      else if (req[b] && !hold && (m_gnt[b] || (auto_en && $urandom_range(0, 15) == 0))) req[b] = 1'b0;
      else if (!req[b] && auto_en && $urandom_range(0, 99) < req_pct) begin
        req[b] = 1'b1;
        cand[b*CW +: CW] = CW'($urandom_range(0, 3));
      end
      if (q_req[b]) begin
        req[b] = 1'b1;
        cand[b*CW +: CW] = CW'(q_cand[b]);
        q_req[b] = 1'b0;
      end
    end
    q_clear = 0;
    if (auto_en && $urandom_range(0, 39) == 0) force_open = 1;
    if (auto_en && $urandom_range(0, 59) == 0) force_close = 1;
    i_open = force_open;
    i_close = force_close;
    force_open = 0;
    force_close = 0;
    rdy = $urandom_range(0, 99) < rdy_pct;
    tif.i_tally_ready = rdy;
    #1;
    for (int b = 0; b < NB; b++) begin
      d = m_cyc - m_ackc[b];
      bv[b] = d >= 1 && d <= LOCK;
    end
    xfer = m_pend && rdy;
    chk("state", 32'(state), 32'(m_state));
    chk("total", total, m_total);
    chk("busy", 32'(busy), 32'(bv));
    chk("valid", 32'(tif.o_tally_valid), 32'(m_pend));
    if (m_pend) begin
      chk("tally_cand", 32'(tif.o_tally_cand), 32'(m_pcand));
      chk("tally_booth", 32'(tif.o_tally_booth), 32'(m_pbooth));
    end
    chk("ack", 32'(ack), xfer ? 32'(1) << m_pbooth : 32'd0);
    chk("rej", 32'(rej), 32'(m_rej));
    nrej = '0;
    m_gnt = '0;
    np = m_pend && !xfer;
    if (xfer) begin
      m_total = (m_total == 32'hFFFF_FFFF) ? m_total : m_total + 32'd1;
      m_ackc[m_pbooth] = m_cyc;
    end
`ifdef BALLOT_TIMEOUT_EN
    if (m_pend && !rdy) begin
      m_stall++;
      if (m_stall == TMO) begin
        np = 0;
        nrej[m_pbooth] = 1'b1;
        m_stall = 0;
      end
    end else m_stall = 0;
`endif
    if (m_state == 1 && !m_pend && !i_close) begin
      win = -1;
      for (int i = 0; i < NB; i++)
        if (win < 0 && req[(m_ptr + i) % NB] && !bv[(m_ptr + i) % NB]) win = (m_ptr + i) % NB;
      if (win >= 0) begin
        m_gnt[win] = 1'b1;
        m_ptr = (win + 1) % NB;
        if (int'(cand[win*CW +: CW]) < NC) begin
          np = 1;
          m_pbooth = win;
          m_pcand = int'(cand[win*CW +: CW]);
        end else nrej[win] = 1'b1;
      end
    end
    case (m_state)
      0, 3: if (i_open) begin m_state = 1; m_clear(); end
      1: if (i_close) m_state = 2;
      2: if (!m_pend) m_state = 3;
      default: ;
    endcase
    m_pend = np;
    m_rej = nrej;
    m_cyc++;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_total"}, total, 32'd0);
    chk({tag, "_valid"}, 32'(tif.o_tally_valid), 32'd0);
    chk({tag, "_cand"}, 32'(tif.o_tally_cand), 32'd0);
    chk({tag, "_booth"}, 32'(tif.o_tally_booth), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rej"}, 32'(rej), 32'd0);
  endtask
  logic [31:0] saved;
  initial begin
    tif.i_tally_ready = 1'b0;
    auto_en = 0; hold = 0; force_open = 0; force_close = 0; q_clear = 0; q_req = '0;
    rdy_pct = 100; req_pct = 30; m_cyc = 0;
    m_reset();
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    force_open = 1;
    tick();
    raise(0, 1);
    raise(2, 2);
    repeat (20) tick();
    chk("t1_total", total, 32'd2);
    hold = 1;
    for (int b = 0; b < NB; b++) raise(b, b % NC);
    repeat (60) tick();
    hold = 0;
    q_clear = 1;
    repeat (20) tick();
    saved = m_total;
    raise(1, 3);
    repeat (6) tick();
    chk("t3_total", total, saved);
    q_clear = 1;
    rdy_pct = 0;
    repeat (20) tick();
    saved = m_total;
    raise(3, 0);
    repeat (4) tick();
    force_close = 1;
    repeat (8) tick();
    rdy_pct = 100;
    repeat (4) tick();
    chk("t4_state", 32'(state), 32'd3);
    chk("t4_total", total, saved + 32'd1);
    force_open = 1;
    tick();
    @(posedge clk);
    #1;
    chk("t5_total", total, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    rdy_pct = 0;
    raise(1, 1);
    repeat (4) tick();
    #2 rst = 1'b0;
    #1 chk_zero("arst");
    m_reset();
    q_clear = 1;
    @(negedge clk);
    rst = 1'b1;
    rdy_pct = 0;
    force_open = 1;
    tick();
    raise(2, 1);
    repeat (80) tick();
    rdy_pct = 100;
    repeat (5) tick();
    auto_en = 1;
    for (int p = 0; p < 8; p++) begin
      rdy_pct = $urandom_range(20, 100);
      req_pct = $urandom_range(10, 60);
      repeat (400) tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
